fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined core, directly upstream of the combinational instruction memory (`instrmemory`).
- Owns the PC and drives the memory byte address. It captures the returned word into the IF/ID pipeline register.
- Supports hazard-unit stalls, branch redirects from EX, and halting when the PC runs past the populated instruction space.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_WORDS, 32, number of instruction words in instruction memory. Legal byte addresses are 0 .. 2*MEM_WORDS-2.
- NOP_INSTR, 16'h0000, bubble word placed in IF/ID when the stage holds no valid instruction.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect  in  1  EX resolved taken branch; load redirect_pc
- redirect_pc  in  16  branch target byte address
- imem_addr  out  16  byte address to instruction memory (= pc)
- imem_instr  in  16  instruction word, combinational from memory
- ifid_instr  out  16  latched instruction
- ifid_pc  out  16  byte address of ifid_instr
- ifid_pc_plus2  out  16  ifid_pc + 2 (link/branch base)
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_is_branch  out  1  predecode: ifid_instr[15:12] == 4'hB (BEQ)
- halted  out  1  fetch FSM in HALT

Behaviour:
- Reset (rst=1 at a rising edge):
  - pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus2=0.
  - ifid_valid=0, ifid_is_branch=0, FSM=RUN, halted=0.
  - Reset overrides every other input.
- imem_addr = pc, combinational. Memory latency is zero, so the word is consumed in the same cycle.
- FSM states RUN, HALT. Priority per edge: rst > redirect > stall > normal.
- RUN, in_range (pc <= 2*MEM_WORDS-2), no stall/redirect:
  - ifid_instr <= imem_instr, ifid_pc <= pc, ifid_pc_plus2 <= pc+2, ifid_valid <= 1.
  - pc <= pc+2.
- RUN, pc out of range: FSM <= HALT. IF/ID loads NOP_INSTR with valid=0. pc holds.
- HALT: pc holds and IF/ID holds the bubble. halted=1. Leaves only via redirect (-> RUN) or rst.
- stall=1, no redirect: pc, IF/ID and FSM all hold their values unchanged, including valid.
- redirect=1, in any state and even with stall=1:
  - pc <= {redirect_pc[15:1],1'b0}. Bit 0 is forced to 0 (halfword alignment).
  - IF/ID flushed: instr=NOP_INSTR, valid=0, is_branch=0. FSM <= RUN.
  - The word fetched in that cycle is discarded.
  - Redirect to an out-of-range target: RUN for one cycle, then HALT on the next edge.
- Arithmetic is 16-bit modulo: pc 16'hFFFE+2 = 16'h0000. This is reachable only if MEM_WORDS=32768.
- ifid_is_branch is registered alongside ifid_instr. It is 0 whenever valid=0.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package `core_pkg`:
  - constants WORD_W=16, OPC_BEQ=4'hB, OPC_ADDI=4'hF, NOP_INSTR.
  - fetch_state_t enum {RUN, HALT}.
- Sub-module `ifid_reg` holds the IF/ID register set (load, hold, flush-to-bubble, reset). It is reused by later stage registers.
- PC next-state logic and the FSM stay inline.

Test Plan:
- Reset, then release; memory loaded with F010, F020, F030:
  - Before the first edge, imem_addr=0.
  - After edge 1: ifid_instr=F010, ifid_pc=0, ifid_valid=1, imem_addr=2.
  - After edge 2: ifid_instr=F020, ifid_pc=2.
- stall=1 for 3 cycles at pc=4 -> imem_addr stays 4 and ifid_instr stays F020 for all 3 cycles. After release, the next edge gives ifid_instr=F030.
- redirect=1, redirect_pc=16'h001B, with stall=1 in the same cycle:
  - The next edge gives pc=16'h001A and ifid_valid=0, ifid_instr=0000.
  - The edge after that gives ifid_instr=B2A4 (word 13), ifid_is_branch=1.
- Run sequentially from 0:
  - At pc=16'h0040, the edge sets halted=1 and ifid_valid=0, with pc frozen at 0040 for 10 cycles.
  - Then redirect to 0 -> halted=0 and fetch resumes with F010.
- rst asserted mid-stream (pc=0x0010, stall=1, redirect=1 simultaneously) -> the next edge gives pc=0, ifid_valid=0, halted=0.
- Redirect to 16'h003E (last legal word) -> one valid fetch of word 31, then HALT on the following edge.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared widths, opcodes and fetch FSM encoding for the 16-bit core
package core_pkg;
   localparam int          WORD_W    = 16;
   localparam logic [3:0]  OPC_BEQ   = 4'hB;
   localparam logic [3:0]  OPC_ADDI  = 4'hF;
   localparam logic [15:0] NOP_INSTR = 16'h0000;
   typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_t;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: pipeline register set with load, hold, flush-to-bubble and reset
module ifid_reg
   import core_pkg::*;
#(
   parameter logic [WORD_W-1:0] BUBBLE = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              flush_i,
   input  logic [WORD_W-1:0] instr_i,
   input  logic [WORD_W-1:0] pc_i,
   output logic [WORD_W-1:0] instr_o,
   output logic [WORD_W-1:0] pc_o,
   output logic [WORD_W-1:0] pc_plus2_o,
   output logic              valid_o,
   output logic              is_branch_o
);
   // flush wins over load; address fields keep their last value on flush
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_o     <= BUBBLE;
         pc_o        <= '0;
         pc_plus2_o  <= '0;
         valid_o     <= 1'b0;
         is_branch_o <= 1'b0;
      end else if (flush_i) begin
         instr_o     <= BUBBLE;
         valid_o     <= 1'b0;
         is_branch_o <= 1'b0;
      end else if (load_i) begin
         instr_o     <= instr_i;
         pc_o        <= pc_i;
         pc_plus2_o  <= pc_i + 16'd2;
         valid_o     <= 1'b1;
         is_branch_o <= instr_i[15:12] == OPC_BEQ;
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, instruction fetch into IF/ID with stall, redirect and halt
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          MEM_WORDS = 32,
   parameter logic [15:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_instr,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc,
   output logic [15:0] ifid_pc_plus2,
   output logic        ifid_valid,
   output logic        ifid_is_branch,
   output logic        halted
);
   import core_pkg::*;
   localparam logic [16:0] LAST_ADDR = 17'(2 * MEM_WORDS - 2);
   logic [15:0]  pc_q, pc_d;
   fetch_state_t state_q, state_d;
   logic         load, flush, in_range;
   assign imem_addr = pc_q;
   assign halted    = state_q == HALT;
   assign in_range  = {1'b0, pc_q} <= LAST_ADDR;
   // redirect beats stall; running off the populated space bubbles IF/ID and halts
   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      load    = 1'b0;
      flush   = 1'b0;
      if (redirect) begin
         pc_d    = {redirect_pc[15:1], 1'b0};
         state_d = RUN;
         flush   = 1'b1;
      end else if (!stall && state_q == RUN) begin
         if (in_range) begin
            load = 1'b1;
            pc_d = pc_q + 16'd2;
         end else begin
            state_d = HALT;
            flush   = 1'b1;
         end
      end
   end
   // PC and fetch FSM state
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end
   ifid_reg #(.BUBBLE(NOP_INSTR)) u_ifid (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .flush_i    (flush),
      .instr_i    (imem_instr),
      .pc_i       (pc_q),
      .instr_o    (ifid_instr),
      .pc_o       (ifid_pc),
      .pc_plus2_o (ifid_pc_plus2),
      .valid_o    (ifid_valid),
      .is_branch_o(ifid_is_branch)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus against a cycle model of the fetch stage
module tb_fetch_stage;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic [15:0] imem_addr, imem_instr, ifid_instr, ifid_pc, ifid_pc_plus2;
   logic        ifid_valid, ifid_is_branch, halted;
   logic [15:0] mem [32];
   int          vectors = 0, errors = 0;
   bit          chk_en = 1'b0;
   int          m_pc = 0, m_pcx = 0;
   bit          m_halt = 1'b0, m_valid = 1'b0;
   logic [15:0] m_instr = 16'h0000;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_instr(imem_instr), .ifid_instr(ifid_instr),
      .ifid_pc(ifid_pc), .ifid_pc_plus2(ifid_pc_plus2), .ifid_valid(ifid_valid),
      .ifid_is_branch(ifid_is_branch), .halted(halted)
   );

   always #5 clk = ~clk;
   assign imem_instr = (imem_addr < 16'd64) ? mem[imem_addr[5:1]] : 16'hDEAD;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: what the IF/ID contents and PC must be after each edge.
   always @(posedge clk) begin
      if (rst) begin
         m_pc = 0; m_halt = 0; m_valid = 0; m_instr = 16'h0000; m_pcx = 0;
      end else if (redirect) begin
         m_pc = redirect_pc & 16'hFFFE; m_halt = 0; m_valid = 0; m_instr = 16'h0000;
      end else if (!stall && !m_halt) begin
         if (m_pc <= 62) begin
            m_instr = mem[m_pc / 2]; m_pcx = m_pc; m_valid = 1; m_pc = (m_pc + 2) % 65536;
         end else begin
            m_halt = 1; m_valid = 0; m_instr = 16'h0000;
         end
      end
   end

   always @(negedge clk) if (chk_en) begin
      chk("imem_addr", imem_addr, 16'(m_pc));
      chk("halted", {15'd0, halted}, {15'd0, m_halt});
      chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_is_branch", {15'd0, ifid_is_branch},
          {15'd0, m_valid && m_instr[15:12] == 4'hB});
      if (m_valid) begin
         chk("ifid_pc", ifid_pc, 16'(m_pcx));
         chk("ifid_pc_plus2", ifid_pc_plus2, 16'(m_pcx + 2));
      end
   end

   task automatic cyc(input bit s, input bit r, input logic [15:0] rpc, input bit rs);
      stall = s; redirect = r; redirect_pc = rpc; rst = rs;
      @(posedge clk); #1;
      stall = 0; redirect = 0; rst = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
      mem[0] = 16'hF010; mem[1] = 16'hF020; mem[2] = 16'hF030;
      mem[13] = 16'hB2A4; mem[31] = 16'hB31F;
      cyc(0, 0, 0, 1);
      chk_en = 1;
      chk("pre_edge_addr", imem_addr, 16'h0000);
      chk("rst_valid", {15'd0, ifid_valid}, 16'd0);
      cyc(0, 0, 0, 0);
      chk("e1_instr", ifid_instr, 16'hF010);
      chk("e1_pc", ifid_pc, 16'h0000);
      chk("e1_valid", {15'd0, ifid_valid}, 16'd1);
      chk("e1_addr", imem_addr, 16'h0002);
      cyc(0, 0, 0, 0);
      chk("e2_instr", ifid_instr, 16'hF020);
      chk("e2_pc", ifid_pc, 16'h0002);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0);
         chk("stall_addr", imem_addr, 16'h0004);
         chk("stall_instr", ifid_instr, 16'hF020);
      end
      cyc(0, 0, 0, 0);
      chk("post_stall_instr", ifid_instr, 16'hF030);
      cyc(1, 1, 16'h001B, 0);
      chk("redir_addr", imem_addr, 16'h001A);
      chk("redir_valid", {15'd0, ifid_valid}, 16'd0);
      chk("redir_instr", ifid_instr, 16'h0000);
      cyc(0, 0, 0, 0);
      chk("w13_instr", ifid_instr, 16'hB2A4);
      chk("w13_branch", {15'd0, ifid_is_branch}, 16'd1);
      cyc(0, 1, 16'h0000, 0);
      for (int i = 0; i < 33; i++) cyc(0, 0, 0, 0);
      chk("halt_flag", {15'd0, halted}, 16'd1);
      chk("halt_valid", {15'd0, ifid_valid}, 16'd0);
      for (int i = 0; i < 10; i++) begin
         cyc(i[0], 0, 0, 0);
         chk("halt_pc", imem_addr, 16'h0040);
      end
      cyc(0, 1, 16'h0000, 0);
      chk("resume_halted", {15'd0, halted}, 16'd0);
      cyc(0, 0, 0, 0);
      chk("resume_instr", ifid_instr, 16'hF010);
      cyc(0, 1, 16'h0010, 0);
      cyc(1, 1, 16'h0030, 1);
      chk("midrst_pc", imem_addr, 16'h0000);
      chk("midrst_valid", {15'd0, ifid_valid}, 16'd0);
      chk("midrst_halted", {15'd0, halted}, 16'd0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 16'h003E, 0);
      cyc(0, 0, 0, 0);
      chk("last_instr", ifid_instr, 16'hB31F);
      chk("last_valid", {15'd0, ifid_valid}, 16'd1);
      chk("last_pc", ifid_pc, 16'h003E);
      cyc(0, 0, 0, 0);
      chk("last_halt", {15'd0, halted}, 16'd1);
      chk("last_bubble", {15'd0, ifid_valid}, 16'd0);
      for (int i = 0; i < 40; i++)
         cyc(i % 3 == 1, i % 7 == 0, 16'(i * 5), i == 23);
      @(negedge clk);
      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
